// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath definitions used by the pipeline stages.
package rv32i_pkg;

    localparam int unsigned DPW = 32;

    // Memory-stage bus handshake states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // M->W pipeline register payload
    typedef struct packed {
        logic           regwrite;
        logic           resultsrc;
        logic [DPW-1:0] aluresult;
        logic [DPW-1:0] readdata;
        logic [4:0]     rd;
    } mw_reg_t;

    // Word alignment test on the two address LSBs
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/memory_stage.sv
// Pipeline M stage: drives the data-memory handshake, stalls upstream while
// waiting for an ack, aborts on timeout or misalignment, and holds the M->W register.
module memory_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           validM,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [4:0]     RdM,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DPW-1:0] dmem_addr,
    output logic [DPW-1:0] dmem_wdata,
    input  logic           dmem_ack,
    input  logic [DPW-1:0] dmem_rdata,
    output logic           stallM,
    output logic           regwriteW,
    output logic           resultsrcW,
    output logic [DPW-1:0] aluresultW,
    output logic [DPW-1:0] readdataW,
    output logic [4:0]     RdW,
    output logic           bus_err,
    output logic           misalign_err
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    mem_state_t    state;
    mem_state_t    state_next;
    logic [CW-1:0] count;
    logic          access;
    logic          aligned;
    logic          timeout;
    logic          complete;
    mw_reg_t       w_q;
    mw_reg_t       w_next;

    assign access  = validM & (resultsrcM | memwriteM);
    assign aligned = is_aligned(aluresultM[1:0]);

    // State register; reset abandons any outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on an un-acked request, leave WAIT on ack or timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dmem_req && !dmem_ack) state_next = WAIT;
            WAIT:    if (dmem_ack || timeout)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus and stall outputs; request is gated by rst so it drops asynchronously
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        timeout    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    dmem_req = access & aligned;
                WAIT:    dmem_req = 1'b1;
                default: dmem_req = 1'b0;
            endcase
            timeout = (state == WAIT) && (count == LAST_CNT) && !dmem_ack;
        end
        if (dmem_req) begin
            dmem_we    = memwriteM;
            dmem_addr  = aluresultM;
            dmem_wdata = Rd2M;
        end
        complete = dmem_req & dmem_ack;
        stallM   = dmem_req & ~dmem_ack & ~timeout;
    end

    // Wait counter: zero outside WAIT, counts WAIT cycles from entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (state == WAIT && state_next == WAIT) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

    // W payload: capture retiring instruction, bubble on stall/abort/invalid
    always_comb begin
        w_next = '0;
        if (validM && !stallM && !timeout && !(access && !aligned)) begin
            w_next.regwrite  = regwriteM;
            w_next.resultsrc = resultsrcM;
            w_next.aluresult = aluresultM;
            w_next.rd        = RdM;
            w_next.readdata  = (resultsrcM && complete) ? dmem_rdata : '0;
        end
    end

    // M->W pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else begin
            w_q <= w_next;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (timeout)             bus_err      <= 1'b1;
            if (access && !aligned)  misalign_err <= 1'b1;
        end
    end

    assign regwriteW  = w_q.regwrite;
    assign resultsrcW = w_q.resultsrc;
    assign aluresultW = w_q.aluresult;
    assign readdataW  = w_q.readdata;
    assign RdW        = w_q.rd;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;
    import rv32i_pkg::*;

    logic           clk;
    logic           rst;
    logic           validM;
    logic           regwriteM;
    logic           resultsrcM;
    logic           memwriteM;
    logic [DPW-1:0] aluresultM;
    logic [DPW-1:0] Rd2M;
    logic [4:0]     RdM;
    logic           dmem_req;
    logic           dmem_we;
    logic [DPW-1:0] dmem_addr;
    logic [DPW-1:0] dmem_wdata;
    logic           dmem_ack;
    logic [DPW-1:0] dmem_rdata;
    logic           stallM;
    logic           regwriteW;
    logic           resultsrcW;
    logic [DPW-1:0] aluresultW;
    logic [DPW-1:0] readdataW;
    logic [4:0]     RdW;
    logic           bus_err;
    logic           misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    memory_stage #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
        .memwriteM(memwriteM), .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stallM(stallM), .regwriteW(regwriteW), .resultsrcW(resultsrcW),
        .aluresultW(aluresultW), .readdataW(readdataW), .RdW(RdW),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive M-stage inputs
    task automatic drive(input logic v, input logic rw, input logic rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd);
        validM = v; regwriteM = rw; resultsrcM = rs; memwriteM = mw;
        aluresultM = alu; Rd2M = d2; RdM = rd;
    endtask

    // Advance to just after the next rising edge
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stallM), 32'd0);
        check("rst_regwriteW", 32'(regwriteW), 32'd0);
        check("rst_errs", {30'd0, bus_err, misalign_err}, 32'd0);

        @(negedge clk);
        rst = 1'b0;

        // Load with same-cycle ack: no stall, data one edge later
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld0_req", 32'(dmem_req), 32'd1);
        check("ld0_stall", 32'(stallM), 32'd0);
        check("ld0_addr", dmem_addr, 32'h100);
        check("ld0_we", 32'(dmem_we), 32'd0);
        after_edge();
        check("ld0_readdataW", readdataW, 32'hDEADBEEF);
        check("ld0_regwriteW", 32'(regwriteW), 32'd1);
        check("ld0_RdW", 32'(RdW), 32'd5);
        check("ld0_resultsrcW", 32'(resultsrcW), 32'd1);

        // Store acked after 3 stall cycles
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFF0000;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h12345678, 5'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_stall", 32'(stallM), 32'd1);
            check("st_we", 32'(dmem_we), 32'd1);
            check("st_addr", dmem_addr, 32'h104);
            check("st_wdata", dmem_wdata, 32'h12345678);
            after_edge();
            check("st_bubble_RdW", 32'(RdW), 32'd0);
            @(negedge clk);
        end
        dmem_ack = 1'b1;
        #1;
        check("st_ack_stall", 32'(stallM), 32'd0);
        check("st_ack_req", 32'(dmem_req), 32'd1);
        after_edge();
        check("st_ret_regwriteW", 32'(regwriteW), 32'd0);
        check("st_ret_aluresultW", aluresultW, 32'h104);
        check("st_ret_readdataW", readdataW, 32'h0);
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9);
        #1;
        check("bubble_req", 32'(dmem_req), 32'd0);
        after_edge();
        check("bubble_regwriteW", 32'(regwriteW), 32'd0);

        // Load never acked: 16 stall cycles, then a 16th WAIT cycle that times out
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd6);
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_stall", 32'(stallM), 32'd1);
            @(negedge clk);
        end
        #1;
        check("to_last_stall", 32'(stallM), 32'd0);
        check("to_last_req", 32'(dmem_req), 32'd1);
        check("to_pre_bus_err", 32'(bus_err), 32'd0);
        after_edge();
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_regwriteW", 32'(regwriteW), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check("to_req_dropped", 32'(dmem_req), 32'd0);

        // Misaligned load with a stray ack: no request, ack ignored
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4);
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        #1;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(stallM), 32'd0);
        check("mis_addr", dmem_addr, 32'h0);
        after_edge();
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_regwriteW", 32'(regwriteW), 32'd0);
        check("mis_readdataW", readdataW, 32'h0);

        // ALU-only instruction passes straight to W; errors stay sticky
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 32'hAAAA, 5'd7);
        #1;
        check("add_req", 32'(dmem_req), 32'd0);
        after_edge();
        check("add_aluresultW", aluresultW, 32'h55);
        check("add_regwriteW", 32'(regwriteW), 32'd1);
        check("add_RdW", 32'(RdW), 32'd7);
        check("add_readdataW", readdataW, 32'h0);
        check("sticky_errs", {30'd0, bus_err, misalign_err}, 32'd3);

        // Reset in the second WAIT cycle, then the load reruns normally
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd8);
        repeat (2) @(negedge clk);
        #1;
        check("rw_pre_stall", 32'(stallM), 32'd1);
        rst = 1'b1;
        #1;
        check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_stall", 32'(stallM), 32'd0);
        check("rw_errs", {30'd0, bus_err, misalign_err}, 32'd0);
        check("rw_aluresultW", aluresultW, 32'h0);
        check("rw_RdW", 32'(RdW), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        check("rw_rerun_req", 32'(dmem_req), 32'd1);
        check("rw_rerun_stall", 32'(stallM), 32'd0);
        after_edge();
        check("rw_rerun_readdataW", readdataW, 32'hCAFEF00D);
        check("rw_rerun_RdW", 32'(RdW), 32'd8);
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check("final_req", 32'(dmem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL expose parameter TIMEOUT_CYC, default 16, meaning the maximum number of cycles spent waiting for dmem_ack before an access is aborted.
REQ-002 SHALL use one clock and an asynchronous, active-high reset; all other ports are listed below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 validM  in  1  M-stage holds a real instruction (0 = bubble).
REQ-006 regwriteM, resultsrcM, memwriteM  in  1 each  control bits from execute; resultsrcM=1 means load.
REQ-007 aluresultM  in  DPW  effective address or ALU result.
REQ-008 Rd2M  in  DPW  store data.
REQ-009 RdM  in  5  destination register.
REQ-010 dmem_req  out  1  bus request; dmem_we  out  1  write enable; dmem_addr  out  DPW; dmem_wdata  out  DPW.
REQ-011 dmem_ack  in  1  access complete; dmem_rdata  in  DPW  load data, valid when dmem_ack=1.
REQ-012 stallM  out  1  freeze upstream; when 1, M inputs are held stable by execute.
REQ-013 regwriteW, resultsrcW  out  1 each; aluresultW, readdataW  out  DPW; RdW  out  5: M->W pipeline register.
REQ-014 bus_err, misalign_err  out  1 each  sticky error flags.

Function
REQ-015 access = validM & (resultsrcM | memwriteM); aligned = (aluresultM[1:0] == 2'b00).
REQ-016 FSM states: IDLE, WAIT.
REQ-017 IDLE: access & aligned -> dmem_req=1 combinationally; dmem_ack=1 in the same cycle completes the access with zero stall; otherwise go to WAIT.
REQ-018 WAIT: dmem_req stays 1; dmem_addr/we/wdata are driven from the held M inputs and stay stable; dmem_ack=1 -> complete and return to IDLE.
REQ-019 dmem_we = memwriteM, dmem_addr = aluresultM, dmem_wdata = Rd2M whenever dmem_req=1; all three SHALL be 0 otherwise.
REQ-020 stallM = dmem_req & ~dmem_ack & ~timeout.
REQ-021 A wait counter clears on entry to WAIT and increments each WAIT cycle; timeout = (state==WAIT) & (count == TIMEOUT_CYC-1) & ~dmem_ack.
REQ-022 On timeout: return to IDLE, set bus_err, and write a bubble to W (regwriteW=0); the instruction retires with no effect.
REQ-023 On access & ~aligned: no bus request, stallM=0, set misalign_err, write a bubble to W.
REQ-024 Completed access or non-memory valid instruction: capture regwriteM, resultsrcM, aluresultM, RdM into W; readdataW = dmem_rdata on a completed load, else 0.
REQ-025 While stallM=1: W register loads a bubble (regwriteW=0, RdW=0).
REQ-026 If validM=0: W loads a bubble.
REQ-027 If dmem_ack and timeout conditions coincide, dmem_ack wins (timeout is gated by ~dmem_ack).
REQ-028 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-029 Error flags stay set until rst.
REQ-030 Load-to-use latency: readdataW is valid on the clock edge after the cycle in which dmem_ack=1.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, counter=0, dmem_req=0, stallM=0, all W outputs 0, bus_err=0, misalign_err=0.
REQ-032 Reset during WAIT abandons the access; dmem_req drops asynchronously.

Structure
REQ-033 DPW comes from rv32i_pkg; a mem_state_t enum (IDLE, WAIT) SHALL be added to rv32i_pkg.
REQ-034 Single flat module with no sub-modules; the FSM, counter, and W register are all in this block.

Verification
REQ-035 Load, addr 0x100, ack in the same cycle with rdata 0xDEADBEEF -> stallM never 1; next cycle readdataW=0xDEADBEEF, regwriteW=1, RdW=RdM.
REQ-036 Store, addr 0x104, data 0x12345678, ack after 3 cycles -> stallM=1 for 3 cycles, dmem_we=1 with stable addr/wdata; W bubbles, then regwriteW=0 store retires.
REQ-037 Load with no ack for 16 cycles (TIMEOUT_CYC=16) -> dmem_req drops after the 16th WAIT cycle, bus_err=1, W bubble, FSM back in IDLE.
REQ-038 Load at addr 0x102 -> dmem_req=0, misalign_err=1, stallM=0, regwriteW=0.
REQ-039 rst asserted on cycle 2 of WAIT -> dmem_req=0 and stallM=0 immediately; all outputs 0; next load executes normally.
REQ-040 ADD result 0x55 with validM=1 and no memory access -> aluresultW=0x55 next cycle, dmem_req stays 0.
